sramlike_axi_responder: RTL and testbench

- Terminates the single SRAM-like data port produced by the dcache/uncached mux and converts each transaction into one AXI single-beat read or write.
- Sits between the mux output (req/wr/size/addr/wdata → rdata/addr_ok/data_ok) and the AXI crossbar.
- Holds at most one transaction in flight; a new request is accepted only after the previous one has completed.
- Fixed AXI fields are tied off at the top level, not in this block: id=0, len=0, burst=INCR, lock/cache/prot=0, wid=0, wlast=1.

---
 rtl/axi_pkg.sv | 29 ++
 rtl/sramlike_axi_responder.sv | 149 ++++++++++++++
 tb/tb_sramlike_axi_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI-side definitions for the SRAM-like responder and the dcache
// writeback path: FSM states, request size codes and the byte-strobe helper.
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 is treated as a full word.
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sramlike_axi_responder.sv
// Converts one SRAM-like data-port transaction at a time into a single-beat
// AXI read or write; fixed AXI fields are tied off by the enclosing top level.
module sramlike_axi_responder
  import axi_pkg::*;
#(
  parameter bit FORCE_WORD_SIZE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state_reg, state_next;
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg, w_done_next;
  logic        data_ok_reg, data_ok_next;
  logic [31:0] rdata_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  ax_size_reg;
  logic [3:0]  wstrb_reg;
  logic        accept;
  logic        capture_rdata;
  logic        aw_ok;
  logic        w_ok;

  // Responses are never errors from this block's point of view.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  always_comb begin
    state_next    = state_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    data_ok_next  = 1'b0;
    accept        = 1'b0;
    capture_rdata = 1'b0;
    aw_ok         = aw_done_reg | awready;
    w_ok          = w_done_reg | wready;
    case (state_reg)
      IDLE: begin
        if (data_req) begin
          accept       = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = data_wr ? WR_AW_W : RD_AR;
        end
      end
      RD_AR: begin
        if (arready) state_next = RD_R;
      end
      RD_R: begin
        if (rvalid) begin
          capture_rdata = 1'b1;
          data_ok_next  = 1'b1;
          state_next    = IDLE;
        end
      end
      WR_AW_W: begin
        // Address and data channels may complete in either order.
        if (aw_ok && w_ok) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WR_B;
        end else begin
          aw_done_next = aw_ok;
          w_done_next  = w_ok;
        end
      end
      WR_B: begin
        if (bvalid) begin
          data_ok_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      data_ok_reg <= 1'b0;
      rdata_reg   <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      ax_size_reg <= '0;
      wstrb_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      data_ok_reg <= data_ok_next;
      if (capture_rdata) rdata_reg <= rdata;
      if (accept) begin
        addr_reg    <= data_addr;
        wdata_reg   <= data_wdata;
        ax_size_reg <= (FORCE_WORD_SIZE || data_size == 2'd3) ? 3'b010 : {1'b0, data_size};
        wstrb_reg   <= size_to_wstrb(data_size, data_addr[1:0]);
      end
    end
  end

  assign data_addr_ok = (state_reg == IDLE);
  assign data_data_ok = data_ok_reg;
  assign data_rdata   = rdata_reg;

  assign araddr  = addr_reg;
  assign arsize  = ax_size_reg;
  assign arvalid = (state_reg == RD_AR);
  assign rready  = (state_reg == RD_R);

  assign awaddr  = addr_reg;
  assign awsize  = ax_size_reg;
  assign awvalid = (state_reg == WR_AW_W) && !aw_done_reg;
  assign wdata   = wdata_reg;
  assign wstrb   = wstrb_reg;
  assign wvalid  = (state_reg == WR_AW_W) && !w_done_reg;
  assign bready  = (state_reg == WR_B);

endmodule

// File: tb/tb_sramlike_axi_responder.sv
// Randomized bench: a cycle-level AXI slave drives both a normal and a
// forced-word-size responder; expectations come from a transaction-level model.
module tb_sramlike_axi_responder;

  logic        clk;
  logic        rst;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic [31:0] data_rdata, araddr, awaddr, wdata;
  logic        data_addr_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready;
  logic [2:0]  arsize, awsize;
  logic [3:0]  wstrb;

  logic [31:0] data_rdata_fw, araddr_fw, awaddr_fw, wdata_fw;
  logic        data_addr_ok_fw, data_data_ok_fw, arvalid_fw, rready_fw;
  logic        awvalid_fw, wvalid_fw, bready_fw;
  logic [2:0]  arsize_fw, awsize_fw;
  logic [3:0]  wstrb_fw;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  logic [31:0] last_rdata;

  sramlike_axi_responder #(.FORCE_WORD_SIZE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  sramlike_axi_responder #(.FORCE_WORD_SIZE(1'b1)) dut_fw (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata_fw), .data_addr_ok(data_addr_ok_fw), .data_data_ok(data_data_ok_fw),
    .araddr(araddr_fw), .arsize(arsize_fw), .arvalid(arvalid_fw), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready_fw),
    .awaddr(awaddr_fw), .awsize(awsize_fw), .awvalid(awvalid_fw), .awready(awready),
    .wdata(wdata_fw), .wstrb(wstrb_fw), .wvalid(wvalid_fw), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready_fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (txn %0d, t=%0t)", tag, got, exp, txn_no, $time);
    end
  endtask

  // Reference rules written as byte arithmetic: lane count and aligned offset.
  function automatic logic [3:0] model_strobe(input logic [1:0] size, input logic [31:0] addr);
    int nbytes = (size == 2'd3) ? 4 : (1 << size);
    int offset = ((addr % 4) / nbytes) * nbytes;
    return 4'(((1 << nbytes) - 1) << offset);
  endfunction

  function automatic logic [2:0] model_axsize(input logic [1:0] size);
    return (size == 2'd3) ? 3'd2 : 3'(size);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    data_req = 1'b0;
    step();
    chk("idle_data_ok", data_data_ok, 1'b0);
    chk("idle_addr_ok", data_addr_ok, 1'b1);
    chk("idle_rdata_hold", data_rdata, last_rdata);
  endtask

  // Issues one request and plays the AXI slave with the given per-channel delays.
  task automatic run_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input int ar_dly, input int aw_dly,
                         input int w_dly, input int resp_dly, input logic [31:0] rd);
    bit aw_done, w_done;
    int k;
    logic [3:0] exp_strb;
    exp_strb = model_strobe(size, addr);
    txn_no++;
    chk("accept_addr_ok", data_addr_ok, 1'b1);
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    step();
    data_req = 1'b0; data_wr = 1'($urandom); data_size = 2'($urandom);
    data_addr = $urandom; data_wdata = $urandom;
    if (!wr) begin
      for (int i = 0; i <= ar_dly; i++) begin
        chk("arvalid", arvalid, 1'b1);
        chk("araddr", araddr, addr);
        chk("arsize", arsize, model_axsize(size));
        chk("arsize_fw", arsize_fw, 3'd2);
        chk("rready_early", rready, 1'b0);
        arready = (i == ar_dly);
        step();
      end
      arready = 1'b0;
      for (int j = 0; j <= resp_dly; j++) begin
        chk("rready", rready, 1'b1);
        chk("arvalid_drop", arvalid, 1'b0);
        chk("data_ok_early", data_data_ok, 1'b0);
        rvalid = (j == resp_dly);
        rdata  = (j == resp_dly) ? rd : $urandom;
        rresp  = 2'($urandom);
        step();
      end
      rvalid = 1'b0;
      chk("rd_data_ok", data_data_ok, 1'b1);
      chk("rd_data_rdata", data_rdata, rd);
      chk("rd_rready_drop", rready, 1'b0);
      last_rdata = rd;
    end else begin
      aw_done = 1'b0; w_done = 1'b0; k = 0;
      while (!(aw_done && w_done) && k < 40) begin
        chk("awvalid", awvalid, !aw_done);
        chk("wvalid", wvalid, !w_done);
        chk("bready_early", bready, 1'b0);
        chk("awaddr", awaddr, addr);
        chk("awsize", awsize, model_axsize(size));
        chk("awsize_fw", awsize_fw, 3'd2);
        chk("wdata", wdata, wd);
        chk("wstrb", wstrb, exp_strb);
        chk("wstrb_fw", wstrb_fw, exp_strb);
        awready = (k >= aw_dly);
        wready  = (k >= w_dly);
        step();
        if (k >= aw_dly) aw_done = 1'b1;
        if (k >= w_dly) w_done = 1'b1;
        k++;
      end
      awready = 1'b0; wready = 1'b0;
      for (int j = 0; j <= resp_dly; j++) begin
        chk("bready", bready, 1'b1);
        chk("awvalid_drop", awvalid, 1'b0);
        chk("wvalid_drop", wvalid, 1'b0);
        chk("data_ok_early", data_data_ok, 1'b0);
        bvalid = (j == resp_dly);
        bresp  = 2'($urandom);
        step();
      end
      bvalid = 1'b0;
      chk("wr_data_ok", data_data_ok, 1'b1);
      chk("wr_rdata_hold", data_rdata, last_rdata);
      chk("wr_bready_drop", bready, 1'b0);
    end
    $display("txn %0d wr=%0d size=%0d addr=%h wdata=%h rdata=%h", txn_no, wr, size, addr, wd, rd);
  endtask

  task automatic reset_in_rd_r();
    txn_no++;
    chk("rst_accept_addr_ok", data_addr_ok, 1'b1);
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1230;
    step();
    data_req = 1'b0;
    arready = 1'b1;
    chk("rst_arvalid", arvalid, 1'b1);
    step();
    arready = 1'b0;
    chk("rst_in_rd_r", rready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_arvalid_0", arvalid, 1'b0);
    chk("rst_rready_0", rready, 1'b0);
    chk("rst_data_ok_0", data_data_ok, 1'b0);
    chk("rst_idle", data_addr_ok, 1'b1);
    chk("rst_rdata_0", data_rdata, 32'h0);
    last_rdata = 32'h0;
    rvalid = 1'b1; rdata = 32'hcafe_f00d;
    step();
    rvalid = 1'b0;
    chk("late_rvalid_data_ok", data_data_ok, 1'b0);
    chk("late_rvalid_rready", rready, 1'b0);
    chk("late_rvalid_rdata", data_rdata, 32'h0);
    $display("txn %0d reset during read response phase", txn_no);
  endtask

  initial begin
    rst = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = '0; rresp = '0; bresp = '0;
    last_rdata = '0;
    repeat (3) step();
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_awvalid", awvalid, 1'b0);
    chk("reset_wvalid", wvalid, 1'b0);
    chk("reset_rready", rready, 1'b0);
    chk("reset_bready", bready, 1'b0);
    chk("reset_data_ok", data_data_ok, 1'b0);
    chk("reset_rdata", data_rdata, 32'h0);
    chk("reset_wstrb", wstrb, 4'h0);
    chk("reset_araddr", araddr, 32'h0);
    chk("reset_awaddr", awaddr, 32'h0);
    chk("reset_arsize_fw", arsize_fw, 3'h0);
    rst = 1'b0;
    step();

    // Minimum-latency word read, then confirm the data_ok pulse is one cycle.
    run_txn(1'b0, 2'd2, 32'h1fc0_0004, 32'h0, 0, 0, 0, 0, 32'hdeadbeef);
    idle_cycle();
    run_txn(1'b1, 2'd0, 32'h1fc0_0003, 32'h1111_1111, 0, 0, 0, 0, 32'h0);
    idle_cycle();
    run_txn(1'b1, 2'd1, 32'h1fc0_0002, 32'h2222_2222, 0, 0, 0, 0, 32'h0);
    idle_cycle();
    // Address channel stalled for three cycles while the data channel completes.
    run_txn(1'b1, 2'd2, 32'h0000_0100, 32'h3333_3333, 0, 3, 0, 1, 32'h0);
    run_txn(1'b1, 2'd3, 32'h0000_0104, 32'h4444_4444, 0, 0, 2, 0, 32'h0);
    // Back-to-back: the write is issued in the read's data_ok cycle.
    run_txn(1'b0, 2'd0, 32'h0000_0201, 32'h0, 2, 0, 0, 2, 32'h5566_7788);
    run_txn(1'b1, 2'd0, 32'h0000_0202, 32'h9999_9999, 0, 0, 0, 0, 32'h0);
    idle_cycle();
    reset_in_rd_r();

    for (int n = 0; n < 200; n++) begin
      run_txn(1'($urandom), 2'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
